// File: rtl/mux_rr_stream.sv
// N-channel stream mux with fixed-select or round-robin arbitration into one registered output beat.
// One cycle from accept to output; while the output beat is stalled, all in_ready bits stay low.
module mux_rr_stream #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;

  logic             w_free;
  logic             w_sel_ok;
  logic             w_gvalid;
  logic [SEL_W-1:0] w_rr_grant;
  logic [SEL_W-1:0] w_grant;
  logic [WIDTH-1:0] w_grant_dat;

  assign w_free   = !r_out_valid || out_ready;
  assign w_sel_ok = (int'(sel) < N_CH);
  assign w_gvalid = mode ? (|in_valid) : (w_sel_ok && in_valid[sel]);
  assign w_grant  = mode ? w_rr_grant : sel;

  // Search starts just after the last grant, so the previous winner is checked last.
  always_comb begin : rr_search
    int               idx;
    logic             found;
    logic [SEL_W-1:0] w_idx;
    w_rr_grant = '0;
    found      = 1'b0;
    idx        = 0;
    w_idx      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      w_idx = SEL_W'(idx);
      if (!found && in_valid[w_idx]) begin
        w_rr_grant = w_idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant_dat = '0;
    in_ready    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant == SEL_W'(i)) w_grant_dat = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = !rst && w_free && w_gvalid && (w_grant == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SEL_W'(N_CH - 1);
    end else if (w_free) begin
      if (w_gvalid) begin
        r_out_data  <= w_grant_dat;
        r_out_ch    <= w_grant;
        r_out_valid <= 1'b1;
        if (mode) r_ptr <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: an 8x8 instance and a 5-channel 16-bit instance.
module tb_mux_rr_stream;

  logic        clk;
  int          n_tests;
  int          n_fail;

  // 8-channel, 8-bit instance
  logic        rst, mode, out_ready;
  logic [2:0]  sel;
  logic [63:0] a_in_data;
  logic [7:0]  a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [2:0]  a_out_ch;
  logic        a_out_valid;

  // 5-channel, 16-bit instance
  logic        b_rst, b_mode, b_out_ready;
  logic [2:0]  b_sel;
  logic [79:0] b_in_data;
  logic [4:0]  b_in_valid, b_in_ready;
  logic [15:0] b_out_data;
  logic [2:0]  b_out_ch;
  logic        b_out_valid;

  mux_rr_stream #(.N_CH(8), .WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
    .out_ready(out_ready)
  );

  mux_rr_stream #(.N_CH(5), .WIDTH(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp4 [3];
    exp4 = '{1, 7, 1};
    n_tests = 0;
    n_fail  = 0;

    rst = 1'b1; mode = 1'b0; sel = 3'd0; out_ready = 1'b1;
    a_in_valid = 8'hFF; a_in_data = '0;
    b_rst = 1'b1; b_mode = 1'b0; b_sel = 3'd0; b_out_ready = 1'b1;
    b_in_valid = 5'h1F; b_in_data = '0;

    // Reset with every channel offering
    tick(); tick();
    check("rst_in_ready",  a_in_ready,  32'h0);
    check("rst_out_valid", a_out_valid, 32'h0);
    check("rst_out_data",  a_out_data,  32'h0);
    check("rst_out_ch",    a_out_ch,    32'h0);

    // Fixed select
    rst = 1'b0;
    for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'(8'h10 + i);
    a_in_data[5*8 +: 8] = 8'hA5;
    sel = 3'd5;
    #1;
    check("fix_in_ready", a_in_ready, 32'h20);
    tick();
    check("fix_out_valid", a_out_valid, 32'h1);
    check("fix_out_data",  a_out_data,  32'hA5);
    check("fix_out_ch",    a_out_ch,    32'h5);
    a_in_valid = 8'hDF;
    #1;
    check("fix_novld_ready", a_in_ready, 32'h0);
    tick();
    check("fix_novld_valid", a_out_valid, 32'h0);
    check("fix_novld_data",  a_out_data,  32'hA5);

    // Round-robin, all valid: starts at ch0 from the reset pointer
    mode = 1'b1; a_in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'(i);
    for (int k = 0; k < 9; k++) begin
      #1;
      check("rr_in_ready", a_in_ready, 32'(1 << (k % 8)));
      tick();
      check("rr_out_ch",    a_out_ch,    32'(k % 8));
      check("rr_out_data",  a_out_data,  32'(k % 8));
      check("rr_out_valid", a_out_valid, 32'h1);
    end

    // Skip and wrap across empty channels; pointer ends at ch1
    a_in_valid = 8'b1000_0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wrap_out_ch", a_out_ch, 32'(exp4[k]));
    end

    // Backpressure: load 3C, then stall while inputs churn
    mode = 1'b0; sel = 3'd3; a_in_valid = 8'h08;
    a_in_data[3*8 +: 8] = 8'h3C;
    tick();
    check("bp_load_data", a_out_data, 32'h3C);
    check("bp_load_ch",   a_out_ch,   32'h3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 8'hFF;
      sel = 3'(k);
      a_in_data = {$urandom, $urandom};
      #1;
      check("bp_in_ready", a_in_ready, 32'h0);
      tick();
      check("bp_hold_data",  a_out_data,  32'h3C);
      check("bp_hold_valid", a_out_valid, 32'h1);
      check("bp_hold_ch",    a_out_ch,    32'h3);
    end
    sel = 3'd2; a_in_data[2*8 +: 8] = 8'h5A; out_ready = 1'b1;
    #1;
    check("bp_drain_ready", a_in_ready, 32'h04);
    tick();
    check("bp_drain_data",  a_out_data,  32'h5A);
    check("bp_drain_ch",    a_out_ch,    32'h2);
    check("bp_drain_valid", a_out_valid, 32'h1);

    // Back to round-robin: resumes after retained pointer (ch1), not after ch7
    mode = 1'b1;
    #1;
    check("resume_ready", a_in_ready, 32'h04);
    tick();
    check("resume_ch0", a_out_ch, 32'h2);
    tick();
    check("resume_ch1", a_out_ch, 32'h3);

    // Reset during a stall drops the held beat
    out_ready = 1'b0;
    tick();
    check("stall_valid", a_out_valid, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_stall_ready", a_in_ready, 32'h0);
    tick();
    check("rst_stall_valid", a_out_valid, 32'h0);
    rst = 1'b0; out_ready = 1'b1;

    // 5-channel instance: out-of-range select, then round-robin wrap at 4
    b_rst = 1'b0; b_mode = 1'b0; b_sel = 3'd6;
    for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = 16'(16'h1000 + i);
    #1;
    check("p5_badsel_ready", b_in_ready, 32'h0);
    tick();
    check("p5_badsel_valid", b_out_valid, 32'h0);
    b_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("p5_rr_ch",   b_out_ch,   32'(k % 5));
      check("p5_rr_data", b_out_data, 32'(16'h1000 + (k % 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
